// File: rtl/seven_seg_reader.sv
// Samples a multiplexed active-low seven-segment display, debounces each digit strobe,
// decodes four digits to BCD and hands them out as a 16-bit frame with valid/ready.
module seven_seg_reader #(
  parameter int STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  dig_sel,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        err,
  output logic        overrun
);

  typedef enum logic {COLLECT = 1'b0, PRESENT = 1'b1} state_t;

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);

  // Returns {known, nibble}; unknown patterns decode to 4'hE.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode = 5'b1_0000;
      7'b1111001: decode = 5'b1_0001;
      7'b0100100: decode = 5'b1_0010;
      7'b0110000: decode = 5'b1_0011;
      7'b0011001: decode = 5'b1_0100;
      7'b0010010: decode = 5'b1_0101;
      7'b0000010: decode = 5'b1_0110;
      7'b1111000: decode = 5'b1_0111;
      7'b0000000: decode = 5'b1_1000;
      7'b0010000: decode = 5'b1_1001;
      7'b1111111: decode = 5'b1_1111;
      default:    decode = 5'b0_1110;
    endcase
  endfunction

  function automatic logic one_hot(input logic [3:0] v);
    case (v)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: one_hot = 1'b1;
      default:                            one_hot = 1'b0;
    endcase
  endfunction

  logic [6:0]  seg_meta_r, seg_sync_r;
  logic [3:0]  sel_meta_r, sel_sync_r;
  logic [10:0] prev_r;
  logic [3:0]  cnt_r, cnt_next;
  logic [15:0] collect_r, collect_next;
  logic [3:0]  mask_r, mask_next;
  state_t      state_r, state_next;
  logic        out_valid_r, out_valid_next;
  logic [15:0] out_data_r, out_data_next;
  logic        err_r, err_next;
  logic        overrun_r, overrun_next;

  logic [10:0] sample_s;
  logic        qual_s, same_s, capture_s, mask_clr_s;
  logic [4:0]  dec_s;

  assign sample_s = {sel_sync_r, seg_sync_r};
  assign qual_s   = one_hot(sel_sync_r);
  assign same_s   = (sample_s == prev_r);
  // Capture fires exactly once per dwell: on the step from CNT_MAX-1 to CNT_MAX.
  assign capture_s = qual_s && same_s && (cnt_r == (CNT_MAX - 4'd1));
  assign dec_s     = decode(seg_sync_r);

  // Stability counter, digit collection and capture error flag.
  always_comb begin
    cnt_next     = cnt_r;
    collect_next = collect_r;
    err_next     = 1'b0;
    if (!qual_s) begin
      cnt_next = 4'd0;
    end else if (!same_s) begin
      cnt_next = 4'd1;
    end else if (cnt_r == CNT_MAX) begin
      cnt_next = cnt_r;
    end else begin
      cnt_next = cnt_r + 4'd1;
    end
    for (int k = 0; k < 4; k++) begin
      if (capture_s && sel_sync_r[k]) begin
        collect_next[4*k +: 4] = dec_s[3:0];
      end else begin
        collect_next[4*k +: 4] = collect_r[4*k +: 4];
      end
    end
    if (capture_s && !dec_s[4]) begin
      err_next = 1'b1;
    end else begin
      err_next = 1'b0;
    end
  end

  // Frame FSM: present a completed mask, or drop it when the consumer is still busy.
  always_comb begin
    state_next     = state_r;
    out_valid_next = out_valid_r;
    out_data_next  = out_data_r;
    overrun_next   = 1'b0;
    mask_clr_s     = 1'b0;
    case (state_r)
      COLLECT: begin
        if (mask_r == 4'b1111) begin
          out_data_next  = collect_r;
          out_valid_next = 1'b1;
          mask_clr_s     = 1'b1;
          state_next     = PRESENT;
        end else begin
          state_next = COLLECT;
        end
      end
      PRESENT: begin
        // The handshake wins; a mask completing now is presented from COLLECT next.
        if (out_valid_r && out_ready) begin
          out_valid_next = 1'b0;
          state_next     = COLLECT;
        end else if (mask_r == 4'b1111) begin
          overrun_next = 1'b1;
          mask_clr_s   = 1'b1;
        end else begin
          state_next = PRESENT;
        end
      end
      default: begin
        state_next     = COLLECT;
        out_valid_next = 1'b0;
      end
    endcase
    mask_next = (mask_clr_s ? 4'b0000 : mask_r) | (capture_s ? sel_sync_r : 4'b0000);
  end

  // All state, including the two-flop input synchronizers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta_r  <= 7'd0;
      seg_sync_r  <= 7'd0;
      sel_meta_r  <= 4'd0;
      sel_sync_r  <= 4'd0;
      prev_r      <= 11'd0;
      cnt_r       <= 4'd0;
      collect_r   <= 16'h0000;
      mask_r      <= 4'b0000;
      state_r     <= COLLECT;
      out_valid_r <= 1'b0;
      out_data_r  <= 16'h0000;
      err_r       <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      seg_meta_r  <= seg_in;
      seg_sync_r  <= seg_meta_r;
      sel_meta_r  <= dig_sel;
      sel_sync_r  <= sel_meta_r;
      prev_r      <= sample_s;
      cnt_r       <= cnt_next;
      collect_r   <= collect_next;
      mask_r      <= mask_next;
      state_r     <= state_next;
      out_valid_r <= out_valid_next;
      out_data_r  <= out_data_next;
      err_r       <= err_next;
      overrun_r   <= overrun_next;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign err       = err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed bench for seven_seg_reader: expected frames are queued as digits are
// driven and popped by a monitor at each handshake.
module tb_seven_seg_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        err;
  logic        overrun;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  int hs_exp = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_word;

  seven_seg_reader #(.STABLE_CNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .err(err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'd0: enc = 7'b1000000;
      4'd1: enc = 7'b1111001;
      4'd2: enc = 7'b0100100;
      4'd3: enc = 7'b0110000;
      4'd4: enc = 7'b0011001;
      4'd5: enc = 7'b0010010;
      4'd6: enc = 7'b0000010;
      4'd7: enc = 7'b1111000;
      4'd8: enc = 7'b0000000;
      4'd9: enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one strobe/pattern for n clock cycles (entered and left at posedge+1).
  task automatic hold(input logic [3:0] s, input logic [6:0] g, input int n);
    dig_sel = s;
    seg_in  = g;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    hold(4'b0000, 7'b1111111, n);
  endtask

  task automatic scan(input logic [15:0] digs, input int n);
    for (int d = 3; d >= 0; d--) hold(4'b0001 << d, enc(digs[4*d +: 4]), n);
  endtask

  // Scoreboard monitor: pulse counters and frame comparison at each handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err) err_cnt++;
      if (overrun) ovr_cnt++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL unexpected_frame observed=%0h expected=none", out_data);
        end else begin
          exp_word = exp_q.pop_front();
          check("frame_data", {16'h0, out_data}, {16'h0, exp_word});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; dig_sel = 4'b0000; seg_in = 7'b1111111; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_data", {16'h0, out_data}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    @(posedge clk); #1;

    // Basic frame 1234 with consumer always ready.
    out_ready = 1'b1;
    exp_q.push_back(16'h1234); hs_exp++;
    scan(16'h1234, 8);
    idle(10);
    @(negedge clk);
    check("basic_handshakes", hs_cnt, hs_exp);
    check("basic_err", err_cnt, 32'd0);
    check("basic_valid_low", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;

    // Dwell one short of the threshold: nothing captured.
    scan(16'h8765, 3);
    scan(16'h8765, 3);
    idle(10);
    @(negedge clk);
    check("short_dwell_hs", hs_cnt, hs_exp);
    check("short_dwell_mask", {28'h0, dut.mask_r}, 32'h0);
    @(posedge clk); #1;
    // Dwell exactly at the threshold: captured.
    exp_q.push_back(16'h8765); hs_exp++;
    scan(16'h8765, 4);
    idle(10);
    @(negedge clk);
    check("exact_dwell_hs", hs_cnt, hs_exp);
    @(posedge clk); #1;

    // Blank on digit3, unknown pattern on digit0.
    exp_q.push_back(16'hF56E); hs_exp++;
    hold(4'b1000, 7'b1111111, 8);
    hold(4'b0100, enc(4'd5), 8);
    hold(4'b0010, enc(4'd6), 8);
    hold(4'b0001, 7'b0111111, 8);
    idle(10);
    @(negedge clk);
    check("badseg_hs", hs_cnt, hs_exp);
    check("badseg_err_pulses", err_cnt, 32'd1);
    @(posedge clk); #1;

    // Consumer stalled across two frames: second one is dropped.
    out_ready = 1'b0;
    scan(16'h5678, 8);
    idle(5);
    @(negedge clk);
    check("stall_valid", {31'h0, out_valid}, 32'h1);
    check("stall_data", {16'h0, out_data}, 32'h5678);
    @(posedge clk); #1;
    scan(16'h9012, 8);
    idle(5);
    @(negedge clk);
    check("overrun_pulses", ovr_cnt, 32'd1);
    check("overrun_data_held", {16'h0, out_data}, 32'h5678);
    check("overrun_valid_held", {31'h0, out_valid}, 32'h1);
    @(posedge clk); #1;
    exp_q.push_back(16'h5678); hs_exp++;
    out_ready = 1'b1;
    idle(5);
    @(negedge clk);
    check("release_hs", hs_cnt, hs_exp);
    check("release_valid_low", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;

    // Multi-hot and empty strobes never qualify.
    hold(4'b0011, enc(4'd3), 20);
    @(negedge clk);
    check("multihot_cnt", {28'h0, dut.cnt_r}, 32'h0);
    check("multihot_mask", {28'h0, dut.mask_r}, 32'h0);
    @(posedge clk); #1;
    hold(4'b0000, enc(4'd3), 20);
    @(negedge clk);
    check("nosel_cnt", {28'h0, dut.cnt_r}, 32'h0);
    check("nosel_mask", {28'h0, dut.mask_r}, 32'h0);
    check("nosel_hs", hs_cnt, hs_exp);
    @(posedge clk); #1;

    // Frame using the remaining digit codes.
    exp_q.push_back(16'h9012); hs_exp++;
    scan(16'h9012, 8);
    idle(10);
    @(negedge clk);
    check("frame9012_hs", hs_cnt, hs_exp);
    @(posedge clk); #1;

    // Reset after three captures discards them.
    hold(4'b1000, enc(4'd4), 8);
    hold(4'b0100, enc(4'd3), 8);
    hold(4'b0010, enc(4'd2), 8);
    idle(3);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_data", {16'h0, out_data}, 32'h0);
    check("midrst_err", {31'h0, err}, 32'h0);
    check("midrst_overrun", {31'h0, overrun}, 32'h0);
    check("midrst_mask", {28'h0, dut.mask_r}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold(4'b0001, enc(4'd1), 8);
    idle(10);
    @(negedge clk);
    check("postrst_valid", {31'h0, out_valid}, 32'h0);
    check("postrst_hs", hs_cnt, hs_exp);
    check("postrst_mask", {28'h0, dut.mask_r}, 32'h1);
    check("final_err_pulses", err_cnt, 32'd1);
    check("final_overrun_pulses", ovr_cnt, 32'd1);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_reader.md
SEVEN_SEG_READER -- requirements
Module: seven_seg_reader

Interface
REQ-001 Parameter STABLE_CNT, default 4: consecutive identical samples required to capture a digit; legal range 2..15.
REQ-002 clk  input  1  single clock; every flop is clocked on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 seg_in  input  7  segment lines from an external multiplexed display, active-low, bit6=g .. bit0=a; asynchronous to clk.
REQ-005 dig_sel  input  4  digit strobes, active-high, expected one-hot, bit0 = least-significant digit; asynchronous to clk.
REQ-006 out_ready  input  1  consumer accepts the frame when high together with out_valid.
REQ-007 out_valid  output  1  frame available.
REQ-008 out_data  output  16  captured frame: BCD digits, digit k in bits [4k+3:4k].
REQ-009 err  output  1  one-cycle pulse when an unrecognised segment pattern is captured.
REQ-010 overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-011 seg_in and dig_sel SHALL pass through a two-flop synchronizer before any use; all latencies below count from the synchronized value.
REQ-012 A sample SHALL be qualified only when synchronized dig_sel has exactly one bit set; 4'b0000 or multi-hot samples SHALL reset the stability counter and capture nothing.
REQ-013 The stability counter SHALL increment, saturating at STABLE_CNT, while {dig_sel, seg_in} equals the previous cycle's value; any change SHALL reload it to 1.
REQ-014 A capture SHALL occur in the cycle the counter reaches STABLE_CNT; exactly one capture per dwell, with no recapture until {dig_sel, seg_in} changes.
REQ-015 Decode table (seg_in -> nibble): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 1111111 (blank)->4'hF.
REQ-016 Any other pattern SHALL store 4'hE for that digit and pulse err on the cycle after capture.
REQ-017 A capture SHALL write the decoded nibble into that digit's slot of a 16-bit collect register and set the digit's bit in a 4-bit capture mask; a later capture of the same digit overwrites its slot.
REQ-018 The FSM SHALL have two states, COLLECT and PRESENT; reset state COLLECT.
REQ-019 COLLECT: when the mask equals 4'b1111, load out_data from the collect register, set out_valid, clear the mask, and go to PRESENT next cycle.
REQ-020 PRESENT: out_valid and out_data SHALL be held stable until out_valid && out_ready; on that edge out_valid SHALL drop and the FSM SHALL return to COLLECT.
REQ-021 Capturing SHALL continue in PRESENT; if the mask reaches 4'b1111 while out_ready is low, overrun SHALL pulse for one cycle, the mask SHALL clear, and out_data SHALL be unchanged.
REQ-022 When the mask completes in the same cycle as the handshake, the handshake SHALL take priority with no overrun; the completed mask SHALL be presented from COLLECT on the following cycle.
REQ-023 A capture and a mask clear in the same cycle SHALL leave only the new digit's bit set.
REQ-024 Minimum capture latency SHALL be 2 synchronizer cycles + STABLE_CNT cycles from an input change; out_valid SHALL rise 1 cycle after the fourth capture.

Reset
REQ-025 rst_n low SHALL asynchronously clear: out_valid=0, out_data=16'h0000, err=0, overrun=0, mask=0, counter=0, synchronizers=0, state=COLLECT.
REQ-026 Reset asserted mid-frame or mid-handshake SHALL discard all partial captures; after release, a frame SHALL be presented only once four fresh captures have occurred.

Verification
REQ-027 Scan digits 3..0 as 1,2,3,4, each held 8 cycles, out_ready=1 -> out_valid for 1 cycle with out_data=16'h1234, err=0.
REQ-028 Hold each digit for only STABLE_CNT-1 synchronized cycles -> no capture and out_valid stays 0; at exactly STABLE_CNT cycles -> capture.
REQ-029 Digit0 pattern 0111111 among otherwise valid digits -> err pulses once and out_data[3:0]=4'hE; blank on digit3 -> out_data[15:12]=4'hF.
REQ-030 out_ready=0 with two full scan frames (5678, then 9012) -> out_data stays 16'h5678, overrun pulses once; raising out_ready -> single handshake.
REQ-031 dig_sel=4'b0011 or 4'b0000 for 20 cycles -> no capture, counter stays reset.
REQ-032 rst_n low for 1 cycle after 3 digits are captured -> all outputs 0; a fourth digit alone does not produce out_valid.
